tile_draw_arbiter: RTL and testbench
====================================

Name: tile_draw_arbiter

Overview:
Shares the single VGA plot port between several tile-drawing requesters, such as the background board sweep, the player FSMs and the bomb module. Each requester asks for one board tile, given as a 4-bit board position plus a 3-bit colour. The arbiter grants requesters round-robin and rasterises the granted tile as TILE_W x TILE_W pixels, one pixel per clock. It sits between the game FSMs and the VGA adapter inputs (x, y, colour, plot).

Parameters:
NUM_REQ, 3, number of requesters; index 0 = background, 1 = players, 2 = bomb.
TILE_W, 10, tile edge in pixels.
GRID, 16, board is GRID x GRID tiles.
ORIGIN_X, 0, pixel x of tile (0,0).
ORIGIN_Y, 0, pixel y of tile (0,0).

Ports:
clock  in  1  system clock (CLOCK_50 domain).
reset_n  in  1  asynchronous reset, active-low.
req  in  NUM_REQ  per-requester draw request; level, held until grant.
req_pos_x  in  4*NUM_REQ  packed tile x; requester i uses bits [4i+3:4i].
req_pos_y  in  4*NUM_REQ  packed tile y, same packing.
req_colour  in  3*NUM_REQ  packed colour; requester i uses bits [3i+2:3i].
grant  out  NUM_REQ  one-hot, one-cycle pulse when a request is accepted.
done  out  NUM_REQ  one-hot, one-cycle pulse when that requester's tile completes.
x  out  10  pixel x to VGA.
y  out  9  pixel y to VGA.
colour  out  3  pixel colour to VGA.
plot  out  1  pixel write enable to VGA.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE; all outputs go to 0.
  - Round-robin pointer goes to 0; latched position and colour are cleared.
  - A draw interrupted by reset is abandoned with no done pulse.
- States: IDLE, DRAW, FINISH. All outputs are registered.
- IDLE:
  - If req != 0 at a clock edge, select the winner: the first set bit found searching upward from the pointer, wrapping to 0.
  - At that edge: latch the winner's pos_x, pos_y and colour; clear the col/row counters; set grant[winner]=1; advance the pointer to (winner+1) mod NUM_REQ.
  - Go to DRAW, or to FINISH if the position is out of range (see below).
- DRAW:
  - One pixel per cycle with plot=1, in row-major order (col fastest).
  - x = ORIGIN_X + pos_x*TILE_W + col, truncated to 10 bits; y = ORIGIN_Y + pos_y*TILE_W + row, truncated to 9 bits.
  - colour = latched colour, constant for the whole tile; 3'b000 is a legal colour.
  - grant is high only during the first DRAW cycle, coincident with pixel (0,0).
  - After pixel (TILE_W-1, TILE_W-1) go to FINISH. Total: exactly TILE_W*TILE_W plot cycles.
- FINISH:
  - plot=0 and done[winner]=1 for exactly one cycle, then return to IDLE.
  - Tile period is 1 + TILE_W*TILE_W + 1 cycles, i.e. 102 with defaults; the next grant is no earlier than the cycle after IDLE.
- Out of range (pos_x >= GRID or pos_y >= GRID):
  - The request is granted, grant pulses, and the pointer advances.
  - Skip DRAW (no plot cycles); go straight to FINISH and pulse done.
- Requests:
  - Changes to req, pos or colour after grant are ignored; a requester must drop req or present a new tile after its done pulse.
  - A requester that drops req before grant is not served and no state is kept for it.
- Simultaneous requests: exactly one grant per arbitration. Under continuous contention each requester is served at least once per NUM_REQ tiles.
- A requester that holds req through done is re-arbitrated normally and gets no priority bonus.
- busy=1 in DRAW and FINISH.

Decomposition:
- Shared package (tile_draw_pkg):
  - Constants TILE_W, GRID, ORIGIN_X, ORIGIN_Y, and the widths POS_W=4, COL_W=3, X_W=10, Y_W=9.
  - State encoding for IDLE/DRAW/FINISH.
  - Requester index constants REQ_BG=0, REQ_PLAYER=1, REQ_BOMB=2.
- Sub-module tile_raster_counter:
  - Inputs clock, reset_n, clear, enable; outputs col, row, last.
  - col/row counter over TILE_W x TILE_W; last is high on the final pixel.
- The round-robin priority select stays inline as combinational logic.

Test Plan:
- Single request: req=001, pos=(3,2), colour=100 -> grant=001 on the first plot cycle; 100 plot cycles covering x 30..39, y 20..29 in row-major order; done=001 one cycle after the last pixel; then idle, busy=0.
- Simultaneous requests: req=111 held, tiles (0,0),(1,0),(2,0) -> grant order 001,010,100, then 001 again; each tile 102 cycles apart.
- Fairness with a repeat requester: req[0] held continuously and req[1] asserted mid-tile -> next grant goes to 1 (pointer already past 0); no requester is granted twice in a row while another waits.
- Out-of-range position: pos_x=15 with GRID=12 -> grant pulse, zero plot cycles, done pulse on the next cycle.
- Reset mid-draw: reset_n low at pixel 47 -> all outputs 0 asynchronously, no done pulse; after release with req=100, grant=100 (pointer restarted at 0, req[0] low).
- Withdrawn request: req[1] pulsed for 1 cycle while busy -> never granted; done[1] never asserts.

Source files
------------

// File: rtl/tile_draw_pkg.sv
// ============================================================================
// tile_draw_pkg -- shared constants, widths and state encoding for the
// tile-draw arbiter and its raster counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package tile_draw_pkg;

    localparam int TILE_W   = 10;
    localparam int GRID     = 16;
    localparam int ORIGIN_X = 0;
    localparam int ORIGIN_Y = 0;

    localparam int POS_W = 4;
    localparam int COL_W = 3;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;

    localparam int REQ_BG     = 0;
    localparam int REQ_PLAYER = 1;
    localparam int REQ_BOMB   = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAW   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/tile_raster_counter.sv
// ============================================================================
// tile_raster_counter -- row-major col/row walk over a TILE_W x TILE_W tile.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tile_raster_counter #(
    parameter int TILE_W = tile_draw_pkg::TILE_W,
    parameter int CW     = (TILE_W > 1) ? $clog2(TILE_W) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    output logic          last
);

    localparam logic [CW-1:0] C_LAST_IDX = CW'(TILE_W - 1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (enable) begin
            if (col == C_LAST_IDX) begin
                col <= '0;
                row <= (row == C_LAST_IDX) ? '0 : row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    assign last = (col == C_LAST_IDX) && (row == C_LAST_IDX);

endmodule

`default_nettype wire

// File: rtl/tile_draw_arbiter.sv
// ============================================================================
// tile_draw_arbiter -- round-robin share of the VGA plot port; rasterises the
// granted board tile one pixel per clock.  Revision: 1.0
// ============================================================================
`default_nettype none

module tile_draw_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int TILE_W   = tile_draw_pkg::TILE_W,
    parameter int GRID     = tile_draw_pkg::GRID,
    parameter int ORIGIN_X = tile_draw_pkg::ORIGIN_X,
    parameter int ORIGIN_Y = tile_draw_pkg::ORIGIN_Y
) (
    input  logic                                    clock,
    input  logic                                    reset_n,
    input  logic [NUM_REQ-1:0]                      req,
    input  logic [tile_draw_pkg::POS_W*NUM_REQ-1:0] req_pos_x,
    input  logic [tile_draw_pkg::POS_W*NUM_REQ-1:0] req_pos_y,
    input  logic [tile_draw_pkg::COL_W*NUM_REQ-1:0] req_colour,
    output logic [NUM_REQ-1:0]                      grant,
    output logic [NUM_REQ-1:0]                      done,
    output logic [tile_draw_pkg::X_W-1:0]           x,
    output logic [tile_draw_pkg::Y_W-1:0]           y,
    output logic [tile_draw_pkg::COL_W-1:0]         colour,
    output logic                                    plot,
    output logic                                    busy
);

    import tile_draw_pkg::*;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TILE_W > 1) ? $clog2(TILE_W) : 1;

    state_t           r_state, w_state_nxt;
    logic [IW-1:0]    r_ptr, w_ptr_nxt, r_win, w_win_nxt;
    logic [POS_W-1:0] r_pos_x, r_pos_y, w_pos_x_nxt, w_pos_y_nxt;
    logic [COL_W-1:0] r_colour, w_colour_nxt;

    logic [X_W-1:0]     w_x_nxt;
    logic [Y_W-1:0]     w_y_nxt;
    logic [COL_W-1:0]   w_out_colour_nxt;
    logic               w_plot_nxt, w_busy_nxt;
    logic [NUM_REQ-1:0] w_grant_nxt, w_done_nxt;

    logic             w_found, w_sel_in_range;
    logic [IW-1:0]    w_sel;
    logic [POS_W-1:0] w_sel_x, w_sel_y;
    logic [COL_W-1:0] w_sel_colour;

    logic          w_clear, w_enable, w_last;
    logic [CW-1:0] w_col, w_row;

    function automatic logic [NUM_REQ-1:0] one_hot(input logic [IW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IW'(s);
    endfunction

    function automatic logic [X_W-1:0] tile_x(input logic [POS_W-1:0] p);
        return X_W'(ORIGIN_X + int'(p) * TILE_W);
    endfunction

    function automatic logic [Y_W-1:0] tile_y(input logic [POS_W-1:0] p);
        return Y_W'(ORIGIN_Y + int'(p) * TILE_W);
    endfunction

    tile_raster_counter #(
        .TILE_W (TILE_W),
        .CW     (CW)
    ) u_raster (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (w_clear),
        .enable  (w_enable),
        .col     (w_col),
        .row     (w_row),
        .last    (w_last)
    );

    // Search upward from the pointer, wrapping, for the first active request.
    always_comb begin
        w_found      = 1'b0;
        w_sel        = '0;
        w_sel_x      = '0;
        w_sel_y      = '0;
        w_sel_colour = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[rr_index(r_ptr, k)]) begin
                w_found = 1'b1;
                w_sel   = rr_index(r_ptr, k);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel == IW'(i)) begin
                w_sel_x      = req_pos_x[i*POS_W +: POS_W];
                w_sel_y      = req_pos_y[i*POS_W +: POS_W];
                w_sel_colour = req_colour[i*COL_W +: COL_W];
            end
        end
        w_sel_in_range = (int'(w_sel_x) < GRID) && (int'(w_sel_y) < GRID);
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_win_nxt        = r_win;
        w_pos_x_nxt      = r_pos_x;
        w_pos_y_nxt      = r_pos_y;
        w_colour_nxt     = r_colour;
        w_x_nxt          = '0;
        w_y_nxt          = '0;
        w_out_colour_nxt = '0;
        w_plot_nxt       = 1'b0;
        w_grant_nxt      = '0;
        w_done_nxt       = '0;
        w_clear          = 1'b0;
        w_enable         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_win_nxt    = w_sel;
                    w_ptr_nxt    = (w_sel == IW'(NUM_REQ - 1)) ? '0 : w_sel + IW'(1);
                    w_pos_x_nxt  = w_sel_x;
                    w_pos_y_nxt  = w_sel_y;
                    w_colour_nxt = w_sel_colour;
                    w_grant_nxt  = one_hot(w_sel);
                    w_clear      = 1'b1;
                    if (w_sel_in_range) begin
                        w_state_nxt      = ST_DRAW;
                        w_plot_nxt       = 1'b1;
                        w_x_nxt          = tile_x(w_sel_x);
                        w_y_nxt          = tile_y(w_sel_y);
                        w_out_colour_nxt = w_sel_colour;
                    end else begin
                        w_state_nxt = ST_FINISH;
                    end
                end
            end
            ST_DRAW: begin
                if (w_last) begin
                    w_state_nxt = ST_FINISH;
                    w_done_nxt  = one_hot(r_win);
                end else begin
                    w_enable         = 1'b1;
                    w_plot_nxt       = 1'b1;
                    w_out_colour_nxt = r_colour;
                    if (w_col == CW'(TILE_W - 1)) begin
                        w_x_nxt = tile_x(r_pos_x);
                        w_y_nxt = tile_y(r_pos_y) + Y_W'(w_row) + Y_W'(1);
                    end else begin
                        w_x_nxt = tile_x(r_pos_x) + X_W'(w_col) + X_W'(1);
                        w_y_nxt = tile_y(r_pos_y) + Y_W'(w_row);
                    end
                end
            end
            ST_FINISH: begin
                // A skipped tile enters here with grant still showing; hold one
                // more cycle so done follows grant rather than coinciding.
                if (grant != '0) begin
                    w_done_nxt = one_hot(r_win);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= IW'(REQ_BG);
            r_win    <= '0;
            r_pos_x  <= '0;
            r_pos_y  <= '0;
            r_colour <= '0;
            x        <= '0;
            y        <= '0;
            colour   <= '0;
            plot     <= 1'b0;
            grant    <= '0;
            done     <= '0;
            busy     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_win    <= w_win_nxt;
            r_pos_x  <= w_pos_x_nxt;
            r_pos_y  <= w_pos_y_nxt;
            r_colour <= w_colour_nxt;
            x        <= w_x_nxt;
            y        <= w_y_nxt;
            colour   <= w_out_colour_nxt;
            plot     <= w_plot_nxt;
            grant    <= w_grant_nxt;
            done     <= w_done_nxt;
            busy     <= w_busy_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tile_draw_arbiter.sv
// ============================================================================
// tb_tile_draw_arbiter -- table-driven single tiles plus contention, fairness,
// reset and withdrawal sequences, scored against expected pixel/event queues.
// ============================================================================
`default_nettype none

module tb_tile_draw_arbiter;

    localparam int NR = 3;
    localparam int TW = 10;
    localparam int GR = 12;

    logic        clock, reset_n;
    logic [2:0]  req;
    logic [11:0] req_pos_x, req_pos_y;
    logic [8:0]  req_colour;
    logic [2:0]  grant, done;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [2:0]  colour;
    logic        plot, busy;

    tile_draw_arbiter #(
        .NUM_REQ(NR), .TILE_W(TW), .GRID(GR), .ORIGIN_X(0), .ORIGIN_Y(0)
    ) dut (
        .clock(clock), .reset_n(reset_n), .req(req),
        .req_pos_x(req_pos_x), .req_pos_y(req_pos_y), .req_colour(req_colour),
        .grant(grant), .done(done), .x(x), .y(y), .colour(colour),
        .plot(plot), .busy(busy)
    );

    typedef struct { int x; int y; int c; } pix_t;
    typedef struct { int kind; int val; int pl; } ev_t;   // kind 0 = grant, 1 = done
    typedef struct {
        logic [2:0] req; int idx; int px; int py; int col;
        int exp_grant; int exp_len;
    } vec_t;

    pix_t pix_q[$];
    ev_t  ev_q[$];
    int tests = 0, fails = 0;
    int cyc = 0, n_plot = 0, n_grant = 0, n_done = 0;
    int grant_cyc = 0, done_cyc = 0, grant_gap = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push_tile(input int px, input int py, input int col);
        if (px < GR && py < GR)
            for (int r = 0; r < TW; r++)
                for (int c = 0; c < TW; c++)
                    pix_q.push_back('{px*TW + c, py*TW + r, col});
    endtask

    task automatic push_ev(input int kind, input int val, input int pl);
        ev_q.push_back('{kind, val, pl});
    endtask

    task automatic set_req(input int idx, input int px, input int py, input int col);
        req_pos_x[idx*4 +: 4]  = 4'(px);
        req_pos_y[idx*4 +: 4]  = 4'(py);
        req_colour[idx*3 +: 3] = 3'(col);
    endtask

    function automatic int cnt_of(input int which);
        return (which == 0) ? n_grant : (which == 1) ? n_done : n_plot;
    endfunction

    task automatic wait_cnt(input int which, input int target, input int bound, input string nm);
        int k;
        k = 0;
        while (cnt_of(which) < target && k < bound) begin
            @(negedge clock);
            #2;
            k++;
        end
        check(nm, 32'(cnt_of(which) >= target), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_plot"},   32'(plot),   0);
        check({tag, "_grant"},  32'(grant),  0);
        check({tag, "_done"},   32'(done),   0);
        check({tag, "_busy"},   32'(busy),   0);
        check({tag, "_x"},      32'(x),      0);
        check({tag, "_y"},      32'(y),      0);
        check({tag, "_colour"}, 32'(colour), 0);
    endtask

    // Scoreboard monitor: every plot/grant/done is matched against the queues.
    always @(negedge clock) begin : monitor
        ev_t  e;
        pix_t p;
        if (reset_n) begin
            cyc++;
            if (plot) begin
                n_plot++;
                check("busy_while_plot", 32'(busy), 1);
                if (pix_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL pixel_unexpected: got x=%0d y=%0d, expected no pixel", x, y);
                end else begin
                    p = pix_q.pop_front();
                    check("pixel_x", 32'(x), p.x);
                    check("pixel_y", 32'(y), p.y);
                    check("pixel_colour", 32'(colour), p.c);
                end
            end
            if (grant != 3'b000) begin
                n_grant++;
                grant_gap = cyc - grant_cyc;
                grant_cyc = cyc;
                if (ev_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL grant_unexpected: got grant=%b, expected none", grant);
                end else begin
                    e = ev_q.pop_front();
                    check("event_kind_grant", 0, e.kind);
                    check("grant_value", 32'(grant), e.val);
                    check("grant_with_plot", 32'(plot), e.pl);
                end
            end
            if (done != 3'b000) begin
                n_done++;
                done_cyc = cyc;
                check("done_no_plot", 32'(plot), 0);
                check("done_busy", 32'(busy), 1);
                if (ev_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL done_unexpected: got done=%b, expected none", done);
                end else begin
                    e = ev_q.pop_front();
                    check("event_kind_done", 1, e.kind);
                    check("done_value", 32'(done), e.val);
                end
            end
        end
    end

    initial begin : main
        vec_t tbl[7];
        int g0, d0, p0;

        req = '0; req_pos_x = '0; req_pos_y = '0; req_colour = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1 check_all_zero("rst");
        repeat (2) @(negedge clock);
        #2 reset_n = 1'b1;

        //          req     idx px  py col grant len
        tbl[0] = '{3'b001, 0,  3,  2, 4,  1, 100};
        tbl[1] = '{3'b010, 1,  0,  0, 0,  2, 100};
        tbl[2] = '{3'b100, 2, 11, 11, 7,  4, 100};
        tbl[3] = '{3'b001, 0, 15,  0, 3,  1,   1};
        tbl[4] = '{3'b010, 1, 12,  3, 5,  2,   1};
        tbl[5] = '{3'b001, 0,  0, 11, 6,  1, 100};
        tbl[6] = '{3'b100, 2,  3, 12, 2,  4,   1};

        for (int i = 0; i < 7; i++) begin
            vec_t v;
            v = tbl[i];
            set_req(v.idx, v.px, v.py, v.col);
            push_ev(0, v.exp_grant, (v.exp_len == TW*TW) ? 1 : 0);
            push_tile(v.px, v.py, v.col);
            push_ev(1, v.exp_grant, 0);
            g0 = n_grant; d0 = n_done;
            req = v.req;
            wait_cnt(0, g0 + 1, 20, "tbl_grant_wait");
            req = '0;
            wait_cnt(1, d0 + 1, 200, "tbl_done_wait");
            check("tbl_tile_len", done_cyc - grant_cyc, v.exp_len);
            @(negedge clock);
            #2 check("tbl_idle_busy", 32'(busy), 0);
        end

        // Contention: all three held, expect 0,1,2,0 at 102-cycle spacing.
        set_req(0, 0, 0, 1); set_req(1, 1, 0, 2); set_req(2, 2, 0, 6);
        push_ev(0, 1, 1); push_tile(0, 0, 1); push_ev(1, 1, 0);
        push_ev(0, 2, 1); push_tile(1, 0, 2); push_ev(1, 2, 0);
        push_ev(0, 4, 1); push_tile(2, 0, 6); push_ev(1, 4, 0);
        push_ev(0, 1, 1); push_tile(0, 0, 1); push_ev(1, 1, 0);
        g0 = n_grant; d0 = n_done;
        req = 3'b111;
        for (int k = 1; k <= 4; k++) begin
            wait_cnt(0, g0 + k, 250, "rr_grant_wait");
            if (k > 1) check("rr_gap", grant_gap, 102);
        end
        req = '0;
        wait_cnt(1, d0 + 4, 250, "rr_done_wait");

        // Fairness: req[0] held, req[1] joins mid-tile and must be served next.
        set_req(0, 1, 1, 5);
        push_ev(0, 1, 1); push_tile(1, 1, 5); push_ev(1, 1, 0);
        push_ev(0, 2, 1); push_tile(2, 2, 3); push_ev(1, 2, 0);
        push_ev(0, 1, 1); push_tile(1, 1, 5); push_ev(1, 1, 0);
        g0 = n_grant; d0 = n_done; p0 = n_plot;
        req = 3'b001;
        wait_cnt(0, g0 + 1, 20, "fair_grant0_wait");
        wait_cnt(2, p0 + 50, 100, "fair_mid_wait");
        set_req(1, 2, 2, 3);
        req = 3'b011;
        wait_cnt(0, g0 + 2, 250, "fair_grant1_wait");
        req = 3'b001;
        wait_cnt(0, g0 + 3, 250, "fair_grant0b_wait");
        req = '0;
        wait_cnt(1, d0 + 3, 250, "fair_done_wait");

        // Reset in the middle of a tile: outputs clear at once, no done.
        set_req(0, 5, 5, 2);
        push_ev(0, 1, 1); push_tile(5, 5, 2);
        g0 = n_grant; d0 = n_done; p0 = n_plot;
        req = 3'b001;
        wait_cnt(0, g0 + 1, 20, "rst_grant_wait");
        req = '0;
        wait_cnt(2, p0 + 48, 100, "rst_pixel47_wait");
        reset_n = 1'b0;
        #1 check_all_zero("mid_rst");
        check("mid_rst_no_done", n_done, d0);
        pix_q.delete();
        ev_q.delete();
        @(negedge clock);
        #2 reset_n = 1'b1;

        // Pointer restarted at 0: with 0 and 1 both asking, 0 wins.
        set_req(0, 0, 1, 1); set_req(1, 1, 1, 2);
        push_ev(0, 1, 1); push_tile(0, 1, 1); push_ev(1, 1, 0);
        g0 = n_grant; d0 = n_done;
        req = 3'b011;
        wait_cnt(0, g0 + 1, 20, "post_rst_grant_wait");
        req = '0;
        wait_cnt(1, d0 + 1, 200, "post_rst_done_wait");

        set_req(2, 7, 3, 7);
        push_ev(0, 4, 1); push_tile(7, 3, 7); push_ev(1, 4, 0);
        g0 = n_grant; d0 = n_done;
        req = 3'b100;
        wait_cnt(0, g0 + 1, 20, "bomb_grant_wait");
        req = '0;
        wait_cnt(1, d0 + 1, 200, "bomb_done_wait");

        // Withdrawn request: one-cycle pulse on req[1] while busy is never served.
        set_req(0, 4, 4, 1);
        push_ev(0, 1, 1); push_tile(4, 4, 1); push_ev(1, 1, 0);
        g0 = n_grant; d0 = n_done; p0 = n_plot;
        req = 3'b001;
        wait_cnt(0, g0 + 1, 20, "wd_grant_wait");
        req = '0;
        wait_cnt(2, p0 + 10, 50, "wd_mid_wait");
        set_req(1, 6, 6, 4);
        req = 3'b010;
        @(negedge clock);
        #2 req = '0;
        wait_cnt(1, d0 + 1, 200, "wd_done_wait");
        repeat (150) @(negedge clock);
        #2;
        check("withdrawn_grants", n_grant, g0 + 1);
        check("withdrawn_dones", n_done, d0 + 1);
        check("final_busy", 32'(busy), 0);

        check("pix_queue_drained", pix_q.size(), 0);
        check("event_queue_drained", ev_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
